keypad_seg_display: RTL and testbench

//  Consumer end of the keypad scanner's 4-bit key code: turns key codes into a
//  4-digit, time-multiplexed 7-segment entry display. Digits 0-9 shift in from
//  the right; code E clears the entry; code F deletes the newest digit.

---
 rtl/keypad_seg_display.sv | 142 ++++++++++++++
 tb/tb_keypad_seg_display.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_seg_display.sv
// rtl/keypad_seg_display.sv - keypad key codes to a 4-digit multiplexed 7-segment entry display
//
// Purpose: accepts key codes from the keypad scanner and keeps a 4-digit entry
// buffer. Digits 0-9 shift in from the right, E clears the entry and F deletes
// the newest digit. The buffer is shown one digit at a time on the 7-segment
// pins, with leading blank digits.
//
// Ports:
//   clk        in   1  system clock
//   rst        in   1  asynchronous active-high reset
//   code       in   4  key code (0-9 digit, A-D ignored, E clear, F delete)
//   code_valid in   1  high while a key is held; not synchronous to clk
//   seg        out  7  {a,b,c,d,e,f,g}, active-high, registered
//   common     out  4  active-low one-hot digit enable, bit0 = rightmost, registered
module keypad_seg_display #(
  parameter int SCAN_DIV = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] code,
  input  logic       code_valid,
  output logic [6:0] seg,
  output logic [3:0] common
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic          sync1;
  logic          sync2;
  logic          prev;
  logic          live;
  logic          armed;
  logic          key_event;
  logic [3:0]    dig [4];
  logic [2:0]    count;
  logic [6:0]    next_seg;

  function automatic logic [6:0] pattern(input logic [3:0] d);
    case (d)
      4'd0:    pattern = 7'b1111110;
      4'd1:    pattern = 7'b0110000;
      4'd2:    pattern = 7'b1101101;
      4'd3:    pattern = 7'b1111001;
      4'd4:    pattern = 7'b0110011;
      4'd5:    pattern = 7'b1011011;
      4'd6:    pattern = 7'b1011111;
      4'd7:    pattern = 7'b1110000;
      4'd8:    pattern = 7'b1111111;
      4'd9:    pattern = 7'b1110011;
      default: pattern = 7'b0000000;
    endcase
  endfunction

  // Synchroniser plus edge detect. After reset the edge flop reads 0, so a key
  // held across reset release would look like a fresh rise. 'armed' only sets
  // once the synchronised level has been seen low from a real sample ('live'
  // marks that sync1 holds a real sample rather than its reset value).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      live  <= 1'b0;
      armed <= 1'b0;
    end else begin
      sync1 <= code_valid;
      sync2 <= sync1;
      prev  <= sync2;
      live  <= 1'b1;
      if (live && !sync1) armed <= 1'b1;
    end
  end

  assign key_event = sync2 & ~prev & armed;

  // Entry buffer; dig[0] is the newest (rightmost) digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig[0] <= 4'd0;
      dig[1] <= 4'd0;
      dig[2] <= 4'd0;
      dig[3] <= 4'd0;
      count  <= 3'd0;
    end else if (key_event) begin
      if (code <= 4'd9) begin
        dig[3] <= dig[2];
        dig[2] <= dig[1];
        dig[1] <= dig[0];
        dig[0] <= code;
        count  <= (count == 3'd4) ? 3'd4 : count + 3'd1;
      end else if (code == 4'hE) begin
        dig[0] <= 4'd0;
        dig[1] <= 4'd0;
        dig[2] <= 4'd0;
        dig[3] <= 4'd0;
        count  <= 3'd0;
      end else if (code == 4'hF && count != 3'd0) begin
        dig[0] <= dig[1];
        dig[1] <= dig[2];
        dig[2] <= dig[3];
        dig[3] <= 4'd0;
        count  <= count - 3'd1;
      end
    end
  end

  // Digit scan: each digit stays selected for SCAN_DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  // Positions at or above count are blank, except a lone 0 for an empty entry.
  always_comb begin
    next_seg = 7'b0000000;
    if ({1'b0, idx} < count)
      next_seg = pattern(dig[idx]);
    else if (count == 3'd0 && idx == 2'd0)
      next_seg = pattern(4'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg    <= 7'b0000000;
      common <= 4'b1111;
    end else begin
      seg    <= next_seg;
      common <= ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_keypad_seg_display.sv
// tb/tb_keypad_seg_display.sv - self-checking bench for keypad_seg_display
module tb_keypad_seg_display;

  localparam int SD = 4;

  logic       clk;
  logic       rst;
  logic [3:0] code;
  logic       code_valid;
  logic [6:0] seg;
  logic [3:0] common;

  keypad_seg_display #(.SCAN_DIV(SD)) dut (
    .clk       (clk),
    .rst       (rst),
    .code      (code),
    .code_valid(code_valid),
    .seg       (seg),
    .common    (common)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clocks since reset release; drives the expected scan position.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    logic [3:0]  code;
    int          hold;
    int          cnt;
    logic [15:0] digs;   // {d3,d2,d1,d0}, d0 = rightmost
  } vec_t;

  vec_t       tbl [17];
  logic [6:0] pat [16];
  int         n_checks;
  int         n_fail;
  logic [3:0] q [$];     // reference model: entered digits, oldest first

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] c, input int hold, input int gap);
    @(negedge clk);
    code       = c;
    code_valid = 1'b1;
    repeat (hold) @(negedge clk);
    code_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic model_key(input logic [3:0] c);
    if (c <= 4'd9) begin
      q.push_back(c);
      if (q.size() > 4) void'(q.pop_front());
    end else if (c == 4'hE) begin
      q.delete();
    end else if (c == 4'hF) begin
      if (q.size() > 0) void'(q.pop_back());
    end
  endtask

  task automatic model_digs(output int cnt, output logic [15:0] d);
    d   = '0;
    cnt = q.size();
    for (int i = 0; i < cnt; i++) d[i*4 +: 4] = q[cnt-1-i];
  endtask

  // Watch one full scan and compare every clock against the expected display.
  task automatic check_display(input string tag, input int cnt, input logic [15:0] digs);
    int         id;
    logic [3:0] exp_c;
    logic [6:0] exp_s;
    for (int k = 0; k < SD * 4; k++) begin
      @(negedge clk);
      id    = ((cyc - 1) / SD) % 4;
      exp_c = 4'b0001 << id;
      exp_c = ~exp_c;
      if (id < cnt)                exp_s = pat[digs[id*4 +: 4]];
      else if (cnt == 0 && id == 0) exp_s = pat[0];
      else                         exp_s = 7'b0000000;
      chk($sformatf("%s common idx%0d", tag, id), 32'(common), 32'(exp_c));
      chk($sformatf("%s seg idx%0d", tag, id), 32'(seg), 32'(exp_s));
    end
  endtask

  initial begin
    int          mc;
    logic [15:0] md;
    logic [3:0]  rc;

    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 16; i++) pat[i] = 7'b0000000;
    pat[0] = 7'b1111110; pat[1] = 7'b0110000; pat[2] = 7'b1101101;
    pat[3] = 7'b1111001; pat[4] = 7'b0110011; pat[5] = 7'b1011011;
    pat[6] = 7'b1011111; pat[7] = 7'b1110000; pat[8] = 7'b1111111;
    pat[9] = 7'b1110011;

    tbl[0]  = '{4'h1, 5,  1, 16'h0001};
    tbl[1]  = '{4'h2, 5,  2, 16'h0012};
    tbl[2]  = '{4'h3, 5,  3, 16'h0123};
    tbl[3]  = '{4'h5, 5,  4, 16'h1235};
    tbl[4]  = '{4'h6, 5,  4, 16'h2356};
    tbl[5]  = '{4'h7, 5,  4, 16'h3567};
    tbl[6]  = '{4'h8, 5,  4, 16'h5678};
    tbl[7]  = '{4'h9, 5,  4, 16'h6789};
    tbl[8]  = '{4'hF, 5,  3, 16'h0678};
    tbl[9]  = '{4'hE, 5,  0, 16'h0000};
    tbl[10] = '{4'hF, 5,  0, 16'h0000};
    tbl[11] = '{4'h4, 40, 1, 16'h0004};
    tbl[12] = '{4'hB, 5,  1, 16'h0004};
    tbl[13] = '{4'hA, 5,  1, 16'h0004};
    tbl[14] = '{4'h0, 5,  2, 16'h0040};
    tbl[15] = '{4'hF, 5,  1, 16'h0004};
    tbl[16] = '{4'hF, 5,  0, 16'h0000};

    // Reset state and idle scan.
    rst        = 1'b1;
    code       = 4'h0;
    code_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset seg", 32'(seg), 32'h0);
    chk("reset common", 32'(common), 32'hF);
    rst = 1'b0;
    check_display("idle", 0, 16'h0000);

    // Directed table.
    for (int i = 0; i < 17; i++) begin
      press(tbl[i].code, tbl[i].hold, 5);
      check_display($sformatf("tbl%0d", i), tbl[i].cnt, tbl[i].digs);
    end

    // Random keys against the queue model.
    q.delete();
    for (int i = 0; i < 40; i++) begin
      rc = 4'($urandom_range(0, 15));
      press(rc, $urandom_range(3, 8), $urandom_range(2, 6));
      model_key(rc);
      model_digs(mc, md);
      check_display($sformatf("rand%0d key%0h", i, rc), mc, md);
    end

    // Reset in the middle of a press, key held across release.
    press(4'hE, 5, 3);
    model_key(4'hE);
    press(4'h1, 5, 3);
    model_key(4'h1);
    press(4'h2, 5, 3);
    model_key(4'h2);
    model_digs(mc, md);
    check_display("pre-rst", mc, md);
    @(negedge clk);
    code       = 4'h3;
    code_valid = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst seg", 32'(seg), 32'h0);
    chk("async rst common", 32'(common), 32'hF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    chk("first common after rst", 32'(common), 32'hE);
    repeat (10) @(negedge clk);
    check_display("held across rst", 0, 16'h0000);
    code_valid = 1'b0;
    repeat (5) @(negedge clk);
    press(4'h7, 5, 5);
    model_key(4'h7);
    model_digs(mc, md);
    check_display("fresh press after rst", mc, md);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
